fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS-style CPU: the initiator side of the instruction-memory interface.
- Owns the PC register and drives the PC address to the combinational instruction memory. Samples the returned instruction word into the IF/ID pipeline register.
- Handles stall, delay-slot-preserving branch redirect (including redirect deferred across a stall), exception flush, and fetch address errors.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 4096, instruction memory depth in 32-bit words; legal range is IM_BASE to IM_BASE+4*IM_WORDS-4.
- EXC_PC, 32'h0000_4180, flush target PC.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- pc  output  32  fetch address to instruction memory (registered PC).
- instr  input  32  instruction word from memory for address pc, same cycle.
- stall  input  1  hazard unit: hold PC and IF/ID.
- redirect_valid  input  1  branch/jump resolved in ID; take redirect_pc after the delay slot.
- redirect_pc  input  32  branch/jump target.
- flush  input  1  exception/eret: discard IF/ID, PC <= EXC_PC.
- if_id_instr  output  32  latched instruction.
- if_id_pc  output  32  PC of latched instruction.
- if_id_pc8  output  32  if_id_pc + 8 (link address).
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_adel  output  1  latched fetch had an address error.

Behaviour:
- Reset (async, rst_n=0), applies immediately regardless of clk:
  - pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_pc8=8, if_id_valid=0, if_id_adel=0.
  - pend_valid=0, pend_pc=0; state=BOOT.
- FSM states: BOOT and RUN.
  - BOOT: first edge after rst_n rises. IF/ID loads instr at RESET_PC with valid=1; PC += 4; go to RUN. stall is ignored in BOOT.
  - RUN persists until reset.
- Address error:
  - adel_now = (pc[1:0]!=0) or pc<IM_BASE or pc>IM_BASE+4*IM_WORDS-4.
  - When adel_now=1, the word loaded into IF/ID is forced to 32'h0000_0000 (nop) and if_id_adel=1.
- RUN priority per rising edge, highest first:
  1. flush: if_id_valid=0, if_id_instr=0, if_id_adel=0; pc=EXC_PC; pend_valid=0. Overrides stall and redirect.
  2. stall:
     - pc and IF/ID hold.
     - If redirect_valid=1: pend_valid=1, pend_pc=redirect_pc. A newer redirect overwrites an older pending one.
  3. Otherwise:
     - IF/ID loads {instr or nop, pc, pc+8, valid=1, adel_now}. This is the delay slot when a redirect is active.
     - Next pc: redirect_valid ? redirect_pc : pend_valid ? pend_pc : pc+4. Then pend_valid=0.
- Latency:
  - pc is visible to memory in the same cycle it is registered.
  - The instruction appears on if_id_* one edge later.
  - A redirect takes effect on pc at the edge it is accepted; the delay slot is latched on that same edge.
- Arithmetic: all 32-bit unsigned; pc+4 and pc+8 wrap modulo 2^32 with no flag, and the wrapped address is caught as adel.
- redirect_pc misalignment is not checked at input; it is caught as adel when fetched.
- Reset mid-operation: all state returns to reset values, including any pending redirect.

Decomposition:
- Shared package/header: RESET_PC, IM_BASE, IM_WORDS, EXC_PC, NOP word, FSM state encodings (BOOT=1'b0, RUN=1'b1).
- One natural sub-module: if_id_reg, the IF/ID pipeline register with load/hold/clear controls, reused by later stage registers.
- PC/next-PC/pending logic stays in fetch_unit.

Test Plan:
- Reset then free-run with memory returning {pc}:
  - pc goes 3000, 3004, 3008.
  - if_id_pc is 3000 then 3004; if_id_pc8=3008 at the first valid instruction.
  - if_id_valid goes 0 then 1 after the first edge.
- stall=1 for 3 cycles at pc=300C: pc and if_id_* are unchanged for 3 edges, then resume with if_id_pc=300C.
- redirect_valid=1, redirect_pc=3100 with pc=3010:
  - Next edge: if_id_pc=3010 (delay slot), pc=3100.
  - Following edge: if_id_pc=3100.
- stall=1 together with redirect 3200 at pc=3020, then stall=0 with redirect_valid=0:
  - if_id_pc becomes 3020, pc=3200, pend_valid clears.
- flush together with stall and redirect: pc=4180, if_id_valid=0, no pending redirect survives.
- redirect_pc=3202:
  - Fetch at 3202 gives if_id_adel=1, if_id_instr=0.
  - Redirect to 7000 (out of range) also gives adel.
  - rst_n pulsed low mid-run gives immediate pc=3000, if_id_valid=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encoding and IF/ID record for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam int unsigned DEF_IM_WORDS = 4096;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
    logic        adel;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus plus pipeline control and IF/ID outputs of the fetch stage.
interface fetch_unit_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc8;
  logic        if_id_valid;
  logic        if_id_adel;

  modport master (
    output pc, if_id_instr, if_id_pc, if_id_pc8, if_id_valid, if_id_adel,
    input  instr, stall, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  pc, if_id_instr, if_id_pc, if_id_pc8, if_id_valid, if_id_adel,
    output instr, stall, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: clear beats load, otherwise hold.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   clear_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  // Clear only kills the slot; pc/pc8 keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q.instr <= '0;
      q_q.pc    <= '0;
      q_q.pc8   <= 32'd8;
      q_q.valid <= 1'b0;
      q_q.adel  <= 1'b0;
    end else if (clear_i) begin
      q_q.instr <= '0;
      q_q.valid <= 1'b0;
      q_q.adel  <= 1'b0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, deferred branch redirect, flush and fetch address check.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter int unsigned IM_WORDS = DEF_IM_WORDS,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         adel_now;
  logic         ifid_load, ifid_clear;
  if_id_t       ifid_d, ifid_q;

  assign adel_now = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST);

  always_comb begin
    ifid_d.instr = adel_now ? NOP_WORD : bus.instr;
    ifid_d.pc    = pc_q;
    ifid_d.pc8   = pc_q + 32'd8;
    ifid_d.valid = 1'b1;
    ifid_d.adel  = adel_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    ifid_load    = 1'b0;
    ifid_clear   = 1'b0;
    unique case (state_q)
      BOOT: begin
        ifid_load = 1'b1;
        pc_d      = pc_q + 32'd4;
        state_d   = RUN;
      end
      RUN: begin
        if (bus.flush) begin
          ifid_clear   = 1'b1;
          pc_d         = EXC_PC;
          pend_valid_d = 1'b0;
        end else if (bus.stall) begin
          // A redirect seen during a stall is parked until the delay slot can be latched.
          if (bus.redirect_valid) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = bus.redirect_pc;
          end
        end else begin
          ifid_load    = 1'b1;
          pend_valid_d = 1'b0;
          if (bus.redirect_valid)  pc_d = bus.redirect_pc;
          else if (pend_valid_q)   pc_d = pend_pc_q;
          else                     pc_d = pc_q + 32'd4;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .clear_i (ifid_clear),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign bus.pc          = pc_q;
  assign bus.if_id_instr = ifid_q.instr;
  assign bus.if_id_pc    = ifid_q.pc;
  assign bus.if_id_pc8   = ifid_q.pc8;
  assign bus.if_id_valid = ifid_q.valid;
  assign bus.if_id_adel  = ifid_q.adel;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit; memory returns the fetch address as the instruction word.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .IM_BASE  (32'h0000_3000),
    .IM_WORDS (4096),
    .EXC_PC   (32'h0000_4180)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.instr = bus.pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] iinstr;
    logic        valid;
    logic        adel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic fl, input logic [31:0] pc, input logic [31:0] ipc,
                              input logic [31:0] iinstr, input logic valid, input logic adel);
    vec_t v;
    v.stall = st; v.rv = rv; v.rpc = rpc; v.flush = fl;
    v.pc = pc; v.ipc = ipc; v.iinstr = iinstr; v.valid = valid; v.adel = adel;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rpc, input logic fl);
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.flush          = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    cmp({tag, ".pc"},    bus.pc,          32'h0000_3000);
    cmp({tag, ".instr"}, bus.if_id_instr, 32'h0);
    cmp({tag, ".ifpc"},  bus.if_id_pc,    32'h0);
    cmp({tag, ".pc8"},   bus.if_id_pc8,   32'h8);
    cmp({tag, ".valid"}, 32'(bus.if_id_valid), 32'h0);
    cmp({tag, ".adel"},  32'(bus.if_id_adel),  32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    //          stall rv  rpc            flush pc             if_pc          if_instr       valid adel
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_3004, 32'h0000_3000, 32'h0000_3000, 1, 0)); // BOOT
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_3008, 32'h0000_3004, 32'h0000_3004, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_300C, 32'h0000_3008, 32'h0000_3008, 1, 0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0000_300C, 32'h0000_3008, 32'h0000_3008, 1, 0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0000_300C, 32'h0000_3008, 32'h0000_3008, 1, 0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0000_300C, 32'h0000_3008, 32'h0000_3008, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_3010, 32'h0000_300C, 32'h0000_300C, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0000_3100,  0, 32'h0000_3100, 32'h0000_3010, 32'h0000_3010, 1, 0)); // delay slot
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_3104, 32'h0000_3100, 32'h0000_3100, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0000_3020,  0, 32'h0000_3020, 32'h0000_3104, 32'h0000_3104, 1, 0));
    vecs.push_back(mk(1, 1, 32'h0000_3200,  0, 32'h0000_3020, 32'h0000_3104, 32'h0000_3104, 1, 0)); // deferred
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0000_3020, 32'h0000_3104, 32'h0000_3104, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_3200, 32'h0000_3020, 32'h0000_3020, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_3204, 32'h0000_3200, 32'h0000_3200, 1, 0));
    vecs.push_back(mk(1, 1, 32'h0000_3300,  0, 32'h0000_3204, 32'h0000_3200, 32'h0000_3200, 1, 0));
    vecs.push_back(mk(1, 1, 32'h0000_3400,  0, 32'h0000_3204, 32'h0000_3200, 32'h0000_3200, 1, 0)); // overwrite
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_3400, 32'h0000_3204, 32'h0000_3204, 1, 0));
    vecs.push_back(mk(1, 1, 32'h0000_3500,  0, 32'h0000_3400, 32'h0000_3204, 32'h0000_3204, 1, 0));
    vecs.push_back(mk(1, 1, 32'h0000_3600,  1, 32'h0000_4180, 32'h0000_3204, 32'h0,         0, 0)); // flush
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_4184, 32'h0000_4180, 32'h0000_4180, 1, 0));
    vecs.push_back(mk(1, 1, 32'h0000_3700,  0, 32'h0000_4184, 32'h0000_4180, 32'h0000_4180, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0000_3800,  0, 32'h0000_3800, 32'h0000_4184, 32'h0000_4184, 1, 0)); // live beats pending
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_3804, 32'h0000_3800, 32'h0000_3800, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0000_3202,  0, 32'h0000_3202, 32'h0000_3804, 32'h0000_3804, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_3206, 32'h0000_3202, 32'h0,         1, 1)); // misaligned
    vecs.push_back(mk(0, 1, 32'h0000_7000,  0, 32'h0000_7000, 32'h0000_3206, 32'h0,         1, 1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_7004, 32'h0000_7000, 32'h0,         1, 1)); // above range
    vecs.push_back(mk(0, 1, 32'h0000_6FFC,  0, 32'h0000_6FFC, 32'h0000_7004, 32'h0,         1, 1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_7000, 32'h0000_6FFC, 32'h0000_6FFC, 1, 0)); // last legal
    vecs.push_back(mk(0, 1, 32'h0000_2FFC,  0, 32'h0000_2FFC, 32'h0000_7000, 32'h0,         1, 1));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC, 32'h0000_2FFC, 32'h0,         1, 1)); // below range
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0,         1, 1)); // pc wraps
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0000_0004, 32'h0000_0000, 32'h0,         1, 1));

    #2 rst_n = 1'b0;
    #1 check_reset("reset");
    #4 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].flush);
      step();
      cmp({tag, ".pc"},    bus.pc,                   vecs[i].pc);
      cmp({tag, ".valid"}, 32'(bus.if_id_valid),     32'(vecs[i].valid));
      cmp({tag, ".instr"}, bus.if_id_instr,          vecs[i].iinstr);
      cmp({tag, ".adel"},  32'(bus.if_id_adel),      32'(vecs[i].adel));
      if (vecs[i].valid) begin
        cmp({tag, ".ifpc"}, bus.if_id_pc,  vecs[i].ipc);
        cmp({tag, ".pc8"},  bus.if_id_pc8, vecs[i].ipc + 32'd8);
      end
    end

    // Park a redirect, then reset asynchronously between edges; the parked target must be gone.
    drive(1'b0, 1'b1, 32'h0000_3100, 1'b0);
    step();
    cmp("seq.redir", bus.pc, 32'h0000_3100);
    drive(1'b1, 1'b1, 32'h0000_3900, 1'b0);
    step();
    cmp("seq.hold", bus.pc, 32'h0000_3100);
    #3 rst_n = 1'b0;
    #1 check_reset("midrst");
    #2 rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    cmp("post.boot.pc",   bus.pc,                32'h0000_3004);
    cmp("post.boot.ifpc", bus.if_id_pc,          32'h0000_3000);
    cmp("post.boot.v",    32'(bus.if_id_valid),  32'h1);
    step();
    cmp("post.run.pc",    bus.pc,                32'h0000_3008);
    cmp("post.run.ifpc",  bus.if_id_pc,          32'h0000_3004);

    // Stall during BOOT is ignored.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    cmp("bootstall.pc",   bus.pc,                32'h0000_3004);
    cmp("bootstall.v",    32'(bus.if_id_valid),  32'h1);
    step();
    cmp("bootstall.hold", bus.pc,                32'h0000_3004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
